// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder: cbus burst responder in front of a single-port
// 32-bit SRAM. Incrementing bursts of len+1 beats, with optional idle gaps
// before every beat and an immediate abort when the initiator drops valid.

package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  cbus_req_t         creq,
  output cbus_resp_t        cresp,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BEAT,
    WR_BEAT,
    GAP
  } state_t;

  localparam bit          HAS_GAP = (WAIT_CYCLES > 0);
  // Value of the gap counter on the final idle cycle of a gap.
  localparam logic [15:0] GAP_END = 16'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       gap_q, gap_d;
  logic [MEM_AW-1:0] base_q, base_d;
  // Index of the final beat (beats - 1), i.e. the latched len field.
  logic [3:0]        lastidx_q, lastidx_d;
  logic              wr_q, wr_d;

  logic [MEM_AW-1:0] beat_addr;
  logic [MEM_AW-1:0] next_addr;
  logic              is_last;

  // Size and the word-offset / upper address bits carry no meaning here.
  logic unused_req;
  assign unused_req = ^{creq.size, creq.addr};

  // Word address wraps naturally at the SRAM top through MEM_AW-bit arithmetic.
  assign beat_addr = base_q + MEM_AW'(cnt_q);
  assign next_addr = beat_addr + MEM_AW'(1);
  assign is_last   = (cnt_q == lastidx_q);

  // Control state: burst FSM, beat counter and gap counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Burst context captured at acceptance; only consulted once a burst is live.
  always_ff @(posedge clk) begin
    base_q    <= base_d;
    lastidx_q <= lastidx_d;
    wr_q      <= wr_d;
  end

  // Next-state and output decode; a dropped valid aborts any live burst at once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    base_d    = base_q;
    lastidx_d = lastidx_q;
    wr_d      = wr_q;
    cresp     = '0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;

    if (state_q != IDLE && !creq.valid) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (creq.valid) begin
            base_d    = creq.addr[MEM_AW+1:2];
            lastidx_d = creq.len;
            wr_d      = creq.is_write;
            cnt_d     = '0;
            gap_d     = '0;
            if (HAS_GAP)
              state_d = GAP;
            else if (creq.is_write)
              state_d = WR_BEAT;
            else
              state_d = RD_WAIT;
          end
        end
        GAP: begin
          if (gap_q == GAP_END) begin
            gap_d   = '0;
            state_d = wr_q ? WR_BEAT : RD_WAIT;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        RD_WAIT: begin
          mem_en   = 1'b1;
          mem_addr = beat_addr;
          state_d  = RD_BEAT;
        end
        RD_BEAT: begin
          cresp.ready = 1'b1;
          cresp.last  = is_last;
          cresp.data  = mem_rdata;
          cnt_d       = cnt_q + 4'd1;
          if (is_last) begin
            state_d = IDLE;
          end else if (HAS_GAP) begin
            state_d = GAP;
          end else begin
            // Prefetch the following word so beats stream one per cycle.
            mem_en   = 1'b1;
            mem_addr = next_addr;
          end
        end
        WR_BEAT: begin
          cresp.ready = 1'b1;
          cresp.last  = is_last;
          mem_en      = 1'b1;
          mem_we      = creq.strobe;
          mem_addr    = beat_addr;
          mem_wdata   = creq.data;
          cnt_d       = cnt_q + 4'd1;
          if (is_last)
            state_d = IDLE;
          else if (HAS_GAP)
            state_d = GAP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: two instances (no wait states and two wait
// states), each with its own SRAM model. A driver issues bursts and pushes the
// expected beats into a scoreboard queue; a monitor pops and compares.

module tb_cbus_sram_responder;
  import cbus_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int NI    = 2;

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          chk;
    int          start;
    int          off;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        mem_init;
  cbus_req_t   creq  [NI];
  cbus_resp_t  cresp [NI];
  logic        mem_en [NI];
  logic [3:0]  mem_we [NI];

  logic [31:0] ref_mem [NI][DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   act = 0;
  bit   quiet = 0;
  bit   tb_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'h9E37_79B1 * 32'(i)) ^ 32'h5A5A_0000;
  endfunction

  function automatic int wait_of(input int inst);
    return inst * 2;
  endfunction

  // Cycle offset of beat k from the cycle in which the request is accepted.
  function automatic int beat_off(input int w, input bit wr, input int k);
    if (wr)
      return (k + 1) * (w + 1);
    else if (w == 0)
      return 2 + k;
    else
      return (k + 1) * (w + 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [31:0]   sram [DEPTH];

    cbus_sram_responder #(.MEM_AW(AW), .WAIT_CYCLES(g * 2)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .creq      (creq[g]),
      .cresp     (cresp[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (addr),
      .mem_wdata (wdata),
      .mem_rdata (rdata)
    );

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      end else if (mem_en[g]) begin
        if (mem_we[g] == 4'b0000)
          rdata <= sram[addr];
        else
          for (int b = 0; b < 4; b++)
            if (mem_we[g][b]) sram[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every ready.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      checks = checks + 1;
      if (cresp[i].last && !cresp[i].ready) begin
        errors = errors + 1;
        $display("FAIL last_without_ready inst%0d cyc %0d: got last=1 ready=0, need last=0", i, cyc);
      end
      if (cresp[i].ready) begin
        checks = checks + 1;
        if (i != act || expq.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_ready inst%0d cyc %0d: got ready=1, need ready=0 (pending %0d)", i, cyc, expq.size());
        end else begin
          mon_e = expq.pop_front();
          checks = checks + 2;
          if (cresp[i].last !== mon_e.last) begin
            errors = errors + 1;
            $display("FAIL beat_last inst%0d cyc %0d: got %0b need %0b", i, cyc, cresp[i].last, mon_e.last);
          end
          if (cyc - mon_e.start != mon_e.off) begin
            errors = errors + 1;
            $display("FAIL beat_timing inst%0d cyc %0d: got offset %0d need %0d", i, cyc, cyc - mon_e.start, mon_e.off);
          end
          if (mon_e.chk) begin
            checks = checks + 1;
            if (cresp[i].data !== mon_e.data) begin
              errors = errors + 1;
              $display("FAIL read_data inst%0d cyc %0d: got %h need %h", i, cyc, cresp[i].data, mon_e.data);
            end
          end
        end
      end
    end
    if (quiet) begin
      checks = checks + 1;
      if ({cresp[act], mem_en[act], mem_we[act]} !== '0) begin
        errors = errors + 1;
        $display("FAIL quiet_outputs inst%0d cyc %0d: got ready=%0b last=%0b data=%h en=%0b we=%b, need all 0",
                 act, cyc, cresp[act].ready, cresp[act].last, cresp[act].data, mem_en[act], mem_we[act]);
      end
    end
    if (tb_done) begin
      checks = checks + 1;
      if (expq.size() != 0) begin
        errors = errors + 1;
        $display("FAIL missing_beats: got %0d beats outstanding, need 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    if (cyc > 40000) begin
      errors = errors + 1;
      $display("FAIL watchdog: got cycle %0d, need completion within 40000", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NI; i++) creq[i].valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one burst; stop>0 ends it after that many beats, by reset or by
  // dropping valid. Returns at posedge+1 with valid still high after a normal
  // last beat, so the caller may chain a new request back-to-back.
  task automatic run_burst(input int inst, input bit wr, input logic [31:0] addr,
                           input int len, input int stop, input bit use_rst);
    int   nb, ncomp, base, k, guard;
    bit   hs, done;
    exp_t e;
    nb    = len + 1;
    ncomp = (stop > 0) ? stop : nb;
    base  = int'((addr / 4) % DEPTH);
    act   = inst;
    for (int j = 0; j < ncomp; j++) begin
      e.start = cyc + 1;
      e.off   = beat_off(wait_of(inst), wr, j);
      e.last  = (j == len);
      e.chk   = !wr;
      e.data  = wr ? 32'h0 : ref_mem[inst][(base + j) % DEPTH];
      expq.push_back(e);
    end
    if (wr)
      for (int j = 0; j < ncomp; j++)
        for (int b = 0; b < 4; b++)
          if (ws[j][b]) ref_mem[inst][(base + j) % DEPTH][8*b +: 8] = wd[j][8*b +: 8];

    creq[inst].valid    = 1'b1;
    creq[inst].is_write = wr;
    creq[inst].size     = 2'b10;
    creq[inst].addr     = addr;
    creq[inst].len      = 4'(len);
    creq[inst].data     = wd[0];
    creq[inst].strobe   = ws[0];

    k = 0;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
      hs = cresp[inst].ready;
      if (hs && stop > 0 && k + 1 == stop && use_rst) resetn = 1'b0;
      @(posedge clk);
      #1;
      if (hs) begin
        k++;
        if (k == nb || (stop > 0 && k == stop)) begin
          done = 1'b1;
        end else begin
          creq[inst].data   = wd[k];
          creq[inst].strobe = ws[k];
        end
      end
    end
    if (!done) creq[inst].valid = 1'b0;
    if (stop > 0) begin
      creq[inst].valid = 1'b0;
      resetn = 1'b1;
      quiet = 1'b1;
      @(posedge clk);
      #1;
      quiet = 1'b0;
    end
  endtask

  task automatic rand_bursts(input int inst, input int n);
    bit          wr, rst;
    int          len, stop;
    logic [31:0] a;
    for (int t = 0; t < n; t++) begin
      wr   = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 15);
      a    = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 40)) << 2) | 32'($urandom_range(0, 3));
      stop = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      rst  = (stop > 0) && ($urandom_range(0, 1) == 1);
      fill_rand();
      run_burst(inst, wr, a, len, stop, rst);
      if (stop == 0) idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    resetn   = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < NI; i++) creq[i] = '0;
    for (int n = 0; n < NI; n++)
      for (int i = 0; i < DEPTH; i++) ref_mem[n][i] = init_word(i);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state on both instances.
    quiet = 1'b1;
    act = 0;
    @(posedge clk);
    #1;
    act = 1;
    @(posedge clk);
    #1;
    quiet = 1'b0;

    // 4-beat write of A0..A3 at 0x100, then a back-to-back 4-beat read.
    for (int k = 0; k < 16; k++) begin
      wd[k] = 32'hA0 + 32'(k);
      ws[k] = 4'hF;
    end
    run_burst(0, 1'b1, 32'h0000_0100, int'(MLEN4), 0, 1'b0);
    fill_rand();
    run_burst(0, 1'b0, 32'h0000_0100, int'(MLEN4), 0, 1'b0);
    idle(2);

    // Single-beat byte-lane write into word 0x41, then read it back.
    wd[0] = 32'h0000_5500;
    ws[0] = 4'b0010;
    run_burst(0, 1'b1, 32'h0000_0104, int'(MLEN1), 0, 1'b0);
    idle(1);
    run_burst(0, 1'b0, 32'h0000_0104, int'(MLEN1), 0, 1'b0);
    idle(1);

    // Zero-strobe beat still handshakes but writes nothing.
    wd[0] = 32'hDEAD_BEEF;
    ws[0] = 4'b0000;
    run_burst(0, 1'b1, 32'h0000_0108, int'(MLEN1), 0, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0108, int'(MLEN1), 0, 1'b0);
    idle(1);

    // 16-beat write across the SRAM top, read back across the wrap and at 0.
    fill_rand();
    run_burst(0, 1'b1, 32'((DEPTH - 2) * 4), int'(MLEN16), 0, 1'b0);
    run_burst(0, 1'b0, 32'((DEPTH - 2) * 4), int'(MLEN16), 0, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0000, int'(MLEN16), 0, 1'b0);
    idle(1);

    // Reset during beat 2 of a write: beats 3-4 must stay unwritten.
    fill_rand();
    run_burst(0, 1'b1, 32'h0000_0200, int'(MLEN4), 2, 1'b1);
    idle(1);
    run_burst(0, 1'b0, 32'h0000_0200, int'(MLEN4), 0, 1'b0);
    idle(1);

    // Valid dropped mid-burst on a write and on a read.
    fill_rand();
    run_burst(0, 1'b1, 32'h0000_0300, 7, 3, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0300, 7, 0, 1'b0);
    run_burst(0, 1'b0, 32'h0000_0300, 7, 2, 1'b0);
    idle(1);

    rand_bursts(0, 30);
    idle(2);

    // Two wait states: 4-beat write, back-to-back 4-beat read, aborts, random.
    for (int k = 0; k < 16; k++) begin
      wd[k] = 32'hB0 + 32'(k);
      ws[k] = 4'hF;
    end
    run_burst(1, 1'b1, 32'h0000_0100, int'(MLEN4), 0, 1'b0);
    run_burst(1, 1'b0, 32'h0000_0100, int'(MLEN4), 0, 1'b0);
    idle(1);
    fill_rand();
    run_burst(1, 1'b1, 32'h0000_0140, int'(MLEN4), 2, 1'b1);
    run_burst(1, 1'b0, 32'h0000_0140, int'(MLEN4), 0, 1'b0);
    idle(1);
    rand_bursts(1, 15);
    idle(2);

    tb_done = 1'b1;
  end

endmodule

// File: doc/cbus_sram_responder.md
CBUS_SRAM_RESPONDER -- requirements
Module: cbus_sram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning SRAM word-address width (depth 2^MEM_AW words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning idle cycles inserted before every beat.
REQ-003 SHALL have port clk, input, 1, meaning the clock.
REQ-004 SHALL have port resetn, input, 1, meaning reset: synchronous, active-low.
REQ-005 SHALL have port creq, input, cbus_req_t, carrying the initiator request: valid, is_write, size, addr, strobe, data and len.
REQ-006 SHALL have port cresp, output, cbus_resp_t, carrying the response: ready, last and data.
REQ-007 SHALL have port mem_en, output, 1, meaning SRAM access enable.
REQ-008 SHALL have port mem_we, output, 4, meaning SRAM byte write enables.
REQ-009 SHALL have port mem_addr, output, MEM_AW, meaning SRAM word address.
REQ-010 SHALL have port mem_wdata, output, 32, meaning SRAM write data.
REQ-011 SHALL have port mem_rdata, input, 32, meaning SRAM read data, valid the cycle after a read with mem_en=1 and mem_we=0.

Function
REQ-012 SHALL implement the cbus responder; beats per burst = len+1, with MLEN1=0, MLEN4=3 and MLEN16=15.
REQ-013 SHALL use a state machine with states IDLE, RD_WAIT, RD_BEAT, WR_BEAT and GAP.
REQ-014 SHALL, in IDLE with creq.valid=1, latch base=addr[MEM_AW+1:2], latch beats=len+1, clear beat counter cnt, and go to GAP if WAIT_CYCLES>0, else RD_WAIT for reads or WR_BEAT for writes.
REQ-015 SHALL compute the beat address as (base+cnt) mod 2^MEM_AW: incrementing, wrapping at the SRAM top, addr[1:0] ignored.
REQ-016 SHALL, in RD_WAIT, drive mem_en=1, mem_we=0 and mem_addr=base+cnt, then go to RD_BEAT.
REQ-017 SHALL, in RD_BEAT, drive cresp.ready=1, cresp.data=mem_rdata and cresp.last=(cnt==beats-1), then increment cnt.
REQ-018 SHALL, in RD_BEAT when WAIT_CYCLES=0 and the beat is not last, issue the next SRAM read in the same cycle, sustaining one beat per cycle.
REQ-019 SHALL give a first-beat read latency of 2 cycles after valid is seen in IDLE when WAIT_CYCLES=0.
REQ-020 SHALL, in WR_BEAT, drive cresp.ready=1, mem_en=1, mem_we=creq.strobe, mem_wdata=creq.data, mem_addr=base+cnt and cresp.last=(cnt==beats-1), then increment cnt.
REQ-021 SHALL treat creq.data as presented per beat, with the initiator advancing data on each ready.
REQ-022 SHALL never complete a write beat with strobe=0 as a byte write; such a beat gives mem_we=0 but still handshakes.
REQ-023 SHALL pass size through without realignment: strobe lanes are used as given for writes, and reads always return the full 32-bit word.
REQ-024 SHALL, in GAP, hold all outputs at 0 for WAIT_CYCLES cycles, then enter the beat or RD_WAIT state; GAP recurs before every beat.
REQ-025 SHALL, after a last beat, return to IDLE, so that a new request asserted the next cycle is accepted as a new burst (a back-to-back write burst followed by a read burst is legal).
REQ-026 SHALL, on creq.valid=0 in any non-IDLE state, abort to IDLE the same cycle with no SRAM write, no ready, and no further beats.
REQ-027 SHALL drive ready=0, last=0 and data=0 when no beat is presented.
REQ-028 SHALL never assert last without ready.
REQ-029 SHALL assert at most one ready per cycle.
REQ-030 SHALL assert exactly beats readies per completed burst.

Reset
REQ-031 SHALL, on resetn=0 at a clock edge, enter IDLE, clear cnt, and drive cresp to 0, mem_en=0 and mem_we=0 in the following cycle.
REQ-032 SHALL, on reset mid-burst, drop the burst with no partial completion and no further SRAM writes; SRAM contents are not cleared.

Verification
REQ-033 SHALL be verified by: 4-beat write to addr 0x100, data 0xA0..0xA3, strobe 4'hF -> ready on 4 consecutive cycles, last on beat 4, SRAM words 0x40..0x43 = 0xA0..0xA3.
REQ-034 SHALL be verified by: 4-beat read of addr 0x100 after REQ-033 -> ready 2 cycles after valid, then 4 consecutive beats 0xA0..0xA3, with last only on 0xA3.
REQ-035 SHALL be verified by: single-beat MLEN1 write to 0x104 with strobe 4'b0010 and data 0x0000_5500 -> only byte 1 of word 0x41 becomes 0x55, with ready and last in the same cycle.
REQ-036 SHALL be verified by: write burst immediately followed by a read burst on the cycle after last -> both complete, and the read returns the just-written data.
REQ-037 SHALL be verified by: WAIT_CYCLES=2, 4-beat read -> exactly 2 idle cycles before each beat, 4 beats, data correct.
REQ-038 SHALL be verified by: a 16-beat write starting at word 2^MEM_AW-2 -> wraps to word 0; and, separately, resetn=0 at beat 2 of a write burst -> beats 3-4 are never written and cresp=0 the next cycle.
